// File: rtl/psum_accumulator.sv
// Multi-pass partial-sum accumulator: sums input-channel passes per pixel in a
// block-RAM buffer, then adds bias, applies optional ReLU and saturates the result.
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int PSUM_DEPTH = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8:0]            i_max_width,
  input  logic [8:0]            i_max_height,
  input  logic [9:0]            i_max_ci,
  input  logic [DATA_WIDTH-1:0] i_bias,
  input  logic                  i_relu_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam int PIX_W = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
  localparam int TOT_W = 18;
  localparam int RW    = ACC_WIDTH + 2;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state_reg, state_next;
  logic [PIX_W-1:0]       pix_reg, pix_next;
  logic [9:0]             ci_cnt_reg, ci_cnt_next;
  logic [9:0]             ci_reg, ci_next;
  logic [TOT_W-1:0]       total_reg, total_next;
  logic [DATA_WIDTH-1:0]  bias_reg, bias_next;
  logic                   relu_reg, relu_next;
  logic                   err_next;
  logic [DATA_WIDTH-1:0]  data_next;
  logic                   valid_next, done_next;
  logic                   fwd_hit_reg;

  logic [TOT_W-1:0]       start_total;
  logic                   start_bad, consume, last_pass, last_pix, we;
  logic signed [ACC_WIDTH-1:0] rd_reg, fwd_data_reg, operand, base, wdata;
  logic signed [RW-1:0]   base_wide, data_wide, bias_wide, result;
  logic [DATA_WIDTH-1:0]  sat_data;

  logic signed [ACC_WIDTH-1:0] psum_mem [PSUM_DEPTH];

  assign start_total = TOT_W'(i_max_width) * TOT_W'(i_max_height);
  assign start_bad   = (i_max_width == '0) || (i_max_height == '0) || (i_max_ci == '0) ||
                       (start_total > TOT_W'(PSUM_DEPTH));
  assign consume     = (state_reg == ACCUM) && i_valid;
  assign last_pass   = (ci_cnt_reg == ci_reg - 10'd1);
  assign last_pix    = (TOT_W'(pix_reg) == total_reg - TOT_W'(1));
  assign we          = consume && !last_pass;
  assign o_busy      = (state_reg == ACCUM);

  // The read port always prefetches the next pixel; a 1x1 tile rewrites the
  // same address every cycle, so the just-written value is forwarded instead.
  assign operand = fwd_hit_reg ? fwd_data_reg : rd_reg;
  assign base    = (ci_cnt_reg == 10'd0) ? '0 : operand;
  assign wdata   = base + {{(ACC_WIDTH-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};

  always_comb begin
    base_wide = {{2{base[ACC_WIDTH-1]}}, base};
    data_wide = {{(RW-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
    bias_wide = {{(RW-DATA_WIDTH){bias_reg[DATA_WIDTH-1]}}, bias_reg};
    result    = base_wide + data_wide + bias_wide;
    if (relu_reg && result[RW-1]) result = '0;
    if (result > SAT_MAX)      sat_data = SAT_MAX[DATA_WIDTH-1:0];
    else if (result < SAT_MIN) sat_data = SAT_MIN[DATA_WIDTH-1:0];
    else                       sat_data = result[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_next  = state_reg;
    pix_next    = pix_reg;
    ci_cnt_next = ci_cnt_reg;
    ci_next     = ci_reg;
    total_next  = total_reg;
    bias_next   = bias_reg;
    relu_next   = relu_reg;
    err_next    = o_err;
    data_next   = o_data;
    valid_next  = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (start_bad) begin
            err_next = 1'b1;
          end else begin
            err_next    = 1'b0;
            total_next  = start_total;
            ci_next     = i_max_ci;
            bias_next   = i_bias;
            relu_next   = i_relu_en;
            pix_next    = '0;
            ci_cnt_next = '0;
            state_next  = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (consume) begin
          pix_next = last_pix ? '0 : pix_reg + PIX_W'(1);
          if (last_pix) ci_cnt_next = ci_cnt_reg + 10'd1;
          if (last_pass) begin
            valid_next = 1'b1;
            data_next  = sat_data;
            if (last_pix) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      pix_reg     <= '0;
      ci_cnt_reg  <= '0;
      ci_reg      <= '0;
      total_reg   <= '0;
      bias_reg    <= '0;
      relu_reg    <= 1'b0;
      o_err       <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_done      <= 1'b0;
      fwd_hit_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pix_reg     <= pix_next;
      ci_cnt_reg  <= ci_cnt_next;
      ci_reg      <= ci_next;
      total_reg   <= total_next;
      bias_reg    <= bias_next;
      relu_reg    <= relu_next;
      o_err       <= err_next;
      o_data      <= data_next;
      o_valid     <= valid_next;
      o_done      <= done_next;
      fwd_hit_reg <= we && (pix_next == pix_reg);
    end
  end

  // Buffer contents need no reset: pass 0 always overwrites before any read is used.
  always_ff @(posedge i_clk) begin
    if (we) psum_mem[pix_reg] <= wdata;
    rd_reg       <= psum_mem[pix_next];
    fwd_data_reg <= wdata;
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: vector table plus corner-case
// sequences, with expected pixels queued at drive time and checked on output.
module tb_psum_accumulator;
  logic        clk, rst, start, relu_en, valid;
  logic [8:0]  max_width, max_height;
  logic [9:0]  max_ci;
  logic [15:0] bias, data;
  logic [15:0] o_data;
  logic        o_valid, o_done, o_busy, o_err;

  psum_accumulator dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_max_width(max_width), .i_max_height(max_height), .i_max_ci(max_ci),
    .i_bias(bias), .i_relu_en(relu_en), .i_data(data), .i_valid(valid),
    .o_data(o_data), .o_valid(o_valid), .o_done(o_done), .o_busy(o_busy), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]        w;
    logic [8:0]        h;
    logic [9:0]        ci;
    logic [15:0]       bias;
    logic              relu;
    logic [0:7][15:0]  din;
    logic [0:3][15:0]  dout;
  } vec_t;

  typedef struct {
    int d;
    bit done;
  } sb_t;

  sb_t sb_q[$];
  int  stim[$];
  int  expv[$];
  int  checks = 0;
  int  errors = 0;
  int  last_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid pixel.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", int'($signed(o_data)), -99999);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("o_data", int'($signed(o_data)), e.d);
          check("o_done", int'(o_done), int'(e.done));
          $display("pixel out data=%0d done=%0b", $signed(o_data), o_done);
        end
      end else if (o_done) begin
        check("done_without_valid", 1, 0);
      end
    end
  end

  task automatic do_start(input int w, input int h, input int ci, input int b, input bit r);
    max_width = w[8:0]; max_height = h[8:0]; max_ci = ci[9:0];
    bias = b[15:0]; relu_en = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_pix(input int d, input bit push, input int exp, input bit done);
    sb_t e;
    valid = 1'b1;
    data  = d[15:0];
    if (push) begin
      e.d = exp; e.done = done;
      sb_q.push_back(e);
      last_exp = exp;
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check({name, "_drain"}, sb_q.size(), 0);
    sb_q.delete();
    @(posedge clk); #1;
    check({name, "_busy_after"}, int'(o_busy), 0);
    check({name, "_hold"}, int'($signed(o_data)), last_exp);
  endtask

  // Drives stim (pass-major) for one job; expv holds the last-pass result per pixel.
  task automatic run_job(input string name, input int w, input int h, input int ci,
                         input int b, input bit r, input bit gaps, input bit poke);
    int n;
    n = w * h;
    do_start(w, h, ci, b, r);
    for (int p = 0; p < ci; p++) begin
      for (int x = 0; x < n; x++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        drive_pix(stim[p*n + x], (p == ci - 1), expv[x], (p == ci - 1) && (x == n - 1));
        if (poke && p == 0 && x == 0) do_start(1, 1, 1, 1000, 1'b1);
      end
    end
    $display("job %s w=%0d h=%0d ci=%0d issued", name, w, h, ci);
    drain(name);
    stim.delete();
    expv.delete();
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   acc, rr, n, b;

    vecs[0] = '{w:9'd2, h:9'd2, ci:10'd1, bias:16'd5, relu:1'b0,
                din:{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{16'd6, 16'd7, 16'd8, 16'd9}};
    vecs[1] = '{w:9'd1, h:9'd1, ci:10'd2, bias:16'd0, relu:1'b0,
                din:{16'd20000, 16'd20000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{16'd32767, 16'd0, 16'd0, 16'd0}};
    vecs[2] = '{w:9'd1, h:9'd1, ci:10'd2, bias:16'd0, relu:1'b0,
                din:{-16'sd20000, -16'sd20000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{-16'sd32768, 16'd0, 16'd0, 16'd0}};
    vecs[3] = '{w:9'd1, h:9'd1, ci:10'd2, bias:16'd0, relu:1'b1,
                din:{-16'sd20000, -16'sd20000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[4] = '{w:9'd2, h:9'd2, ci:10'd2, bias:-16'sd30, relu:1'b0,
                din:{16'd10, -16'sd10, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{-16'sd20, -16'sd40, -16'sd30, -16'sd25}};
    vecs[5] = '{w:9'd2, h:9'd1, ci:10'd2, bias:16'd100, relu:1'b1,
                din:{-16'sd50, 16'd7, -16'sd60, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{16'd0, 16'd110, 16'd0, 16'd0}};
    vecs[6] = '{w:9'd1, h:9'd2, ci:10'd1, bias:16'd32767, relu:1'b0,
                din:{16'd1, -16'sd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{16'd32767, 16'd32766, 16'd0, 16'd0}};
    vecs[7] = '{w:9'd1, h:9'd1, ci:10'd3, bias:16'd0, relu:1'b0,
                din:{16'd10, 16'd20, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                dout:{16'd60, 16'd0, 16'd0, 16'd0}};

    rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; bias = '0; relu_en = 1'b0;
    max_width = '0; max_height = '0; max_ci = '0;
    #2;
    check("rst_o_data", int'(o_data), 0);
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_done", int'(o_done), 0);
    check("rst_o_busy", int'(o_busy), 0);
    check("rst_o_err", int'(o_err), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // i_valid in IDLE must produce nothing
    for (int k = 0; k < 3; k++) drive_pix(123, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    check("idle_valid_busy", int'(o_busy), 0);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      n = int'(v.w) * int'(v.h);
      for (int k = 0; k < n * int'(v.ci); k++) stim.push_back(int'($signed(v.din[k])));
      for (int k = 0; k < n; k++) expv.push_back(int'($signed(v.dout[k])));
      run_job($sformatf("vec%0d", i), int'(v.w), int'(v.h), int'(v.ci),
              int'($signed(v.bias)), v.relu, 1'b0, 1'b0);
    end

    // 3x1, three passes of 100 with random gaps
    for (int k = 0; k < 9; k++) stim.push_back(100);
    for (int k = 0; k < 3; k++) expv.push_back(300);
    run_job("gaps", 3, 1, 3, 0, 1'b0, 1'b1, 1'b0);

    // 8x4, three passes of random data against a reference model
    b = int'($urandom_range(0, 2000)) - 1000;
    for (int k = 0; k < 96; k++) stim.push_back(int'($urandom_range(0, 24000)) - 12000);
    for (int x = 0; x < 32; x++) begin
      acc = 0;
      for (int p = 0; p < 3; p++) acc += stim[p*32 + x];
      rr = acc + b;
      if (rr < 0) rr = 0;
      if (rr > 32767) rr = 32767;
      expv.push_back(rr);
    end
    run_job("random", 8, 4, 3, b, 1'b1, 1'b1, 1'b0);

    // configuration errors
    do_start(100, 100, 1, 0, 1'b0);
    check("err_oversize", int'(o_err), 1);
    check("err_oversize_busy", int'(o_busy), 0);
    @(posedge clk); #1;
    check("err_sticky", int'(o_err), 1);
    do_start(0, 4, 1, 0, 1'b0);
    check("err_zero_width", int'(o_err), 1);
    do_start(4, 4, 0, 0, 1'b0);
    check("err_zero_ci", int'(o_err), 1);
    check("err_zero_ci_busy", int'(o_busy), 0);
    do_start(64, 64, 1, 0, 1'b0);
    check("err_cleared_by_start", int'(o_err), 0);
    check("max_tile_busy", int'(o_busy), 1);
    rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk); #1;

    // start pulsed mid-run with a different config must be ignored
    stim = '{11, 22, 33, 44};
    expv = '{11 + 33 - 5, 22 + 44 - 5};
    run_job("poke", 2, 1, 2, -5, 1'b0, 1'b0, 1'b1);

    // asynchronous reset mid pass 1, then clean runs
    do_start(2, 1, 2, 0, 1'b0);
    drive_pix(50, 1'b0, 0, 1'b0);
    drive_pix(60, 1'b0, 0, 1'b0);
    drive_pix(5, 1'b1, 55, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("pre_reset_busy", int'(o_busy), 1);
    rst = 1'b1;
    #1;
    check("async_rst_o_data", int'(o_data), 0);
    check("async_rst_o_busy", int'(o_busy), 0);
    check("async_rst_o_valid", int'(o_valid), 0);
    check("async_rst_o_err", int'(o_err), 0);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    stim = '{7};
    expv = '{7};
    run_job("after_rst_ci1", 1, 1, 1, 0, 1'b0, 1'b0, 1'b0);
    stim = '{1, 2, 3, 4};
    expv = '{4, 6};
    run_job("after_rst_ci2", 2, 1, 2, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
